// File: rtl/pipe_hazard_ctrl.sv
// Issue-stage hazard controller: tracks in-flight writers in a small scoreboard
// and decides per cycle whether ID stalls or which stage each operand forwards from.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 32,
    parameter int SELW       = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic                        flush,
    input  logic                        fwd_mode,
    input  logic                        clr_cnt,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_dest,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    output logic                        stall,
    output logic [NUM_SRC*SELW-1:0]     fwd_sel,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            load_use_cnt,
    output logic [CNT_W-1:0]            fwd_cnt,
    output logic [CNT_W-1:0]            issue_cnt
);

    // Scoreboard: index 0 is the instruction just issued (EX), the last index is WB.
    logic [PIPE_DEPTH-1:0] sb_v_reg;
    logic [PIPE_DEPTH-1:0] sb_wr_reg;
    logic [PIPE_DEPTH-1:0] sb_ld_reg;
    logic [REG_AW-1:0]     sb_dest_reg [PIPE_DEPTH];

    logic [NUM_SRC*PIPE_DEPTH-1:0] match;
    logic [NUM_SRC-1:0]            fwd_nz;
    logic                          raw_hazard;
    logic                          lu_hazard;
    logic                          hazard;
    logic                          issue;
    logic                          load_use_stall;
    logic [CNT_W-1:0]              fwd_pop;
    logic [3:0][CNT_W-1:0]         cnt_inc;

    genvar gi, gk;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] src_addr;
            logic [SELW-1:0]   sel;

            assign src_addr = id_src_addr[gi*REG_AW +: REG_AW];

            // r0 is hard-wired to zero, so it never creates a dependency.
            for (gk = 0; gk < PIPE_DEPTH; gk++) begin : g_stage
                assign match[gi*PIPE_DEPTH + gk] = id_src_used[gi] & sb_v_reg[gk] & sb_wr_reg[gk]
                                                 & (sb_dest_reg[gk] == src_addr) & (|src_addr);
            end

            // Scan oldest to youngest so the youngest producer overwrites older ones.
            always_comb begin
                sel = '0;
                if (fwd_mode) begin
                    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                        if (match[gi*PIPE_DEPTH + k]) begin
                            sel = SELW'(k + 1);
                        end
                    end
                end
            end

            assign fwd_sel[gi*SELW +: SELW] = sel;
            assign fwd_nz[gi]               = |sel;
        end
    endgenerate

    // Without forwarding, WB writes in the first half-cycle so only EX..MEM conflict.
    always_comb begin
        raw_hazard = 1'b0;
        lu_hazard  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
                raw_hazard = raw_hazard | match[s*PIPE_DEPTH + k];
            end
            lu_hazard = lu_hazard | (match[s*PIPE_DEPTH] & sb_ld_reg[0]);
        end
    end

    assign hazard         = fwd_mode ? lu_hazard : raw_hazard;
    assign stall          = id_valid & hazard & ~flush;
    assign issue          = id_valid & ~stall & ~flush;
    assign load_use_stall = stall & fwd_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_v_reg  <= '0;
            sb_wr_reg <= '0;
            sb_ld_reg <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                sb_dest_reg[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
                sb_v_reg[k]    <= sb_v_reg[k-1];
                sb_wr_reg[k]   <= sb_wr_reg[k-1];
                sb_ld_reg[k]   <= sb_ld_reg[k-1];
                sb_dest_reg[k] <= sb_dest_reg[k-1];
            end
            // A stall or flush inserts a bubble, which lets a RAW drain on its own.
            sb_v_reg[0]    <= issue;
            sb_wr_reg[0]   <= issue & id_reg_write;
            sb_ld_reg[0]   <= issue & id_is_load;
            sb_dest_reg[0] <= issue ? id_dest : '0;
        end
    end

    always_comb begin
        fwd_pop = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_pop = fwd_pop + CNT_W'(fwd_nz[s]);
        end
    end

    always_comb begin
        cnt_inc[0] = CNT_W'(stall);
        cnt_inc[1] = CNT_W'(load_use_stall);
        cnt_inc[2] = issue ? fwd_pop : '0;
        cnt_inc[3] = CNT_W'(issue);
    end

    // Event counters: clear beats hold, hold beats increment, increments saturate.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W:0]   sum_next;

            assign sum_next = {1'b0, cnt_reg} + {1'b0, cnt_inc[gi]};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (clr_cnt) begin
                    cnt_reg <= '0;
                end else if (!hold) begin
                    cnt_reg <= sum_next[CNT_W] ? '1 : sum_next[CNT_W-1:0];
                end
            end
        end
    endgenerate

    assign stall_cnt    = g_cnt[0].cnt_reg;
    assign load_use_cnt = g_cnt[1].cnt_reg;
    assign fwd_cnt      = g_cnt[2].cnt_reg;
    assign issue_cnt    = g_cnt[3].cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: expectations are queued as stimulus is applied and
// drained on the following falling edge, one line per failed comparison.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int NUM_SRC    = 2;
    localparam int PIPE_DEPTH = 3;
    localparam int CNT_W      = 4;
    localparam int SELW       = 2;

    localparam int K_STALL = 0;
    localparam int K_SEL0  = 1;
    localparam int K_SEL1  = 2;
    localparam int K_SCNT  = 3;
    localparam int K_LCNT  = 4;
    localparam int K_FCNT  = 5;
    localparam int K_ICNT  = 6;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      hold = 1'b0;
    logic                      flush = 1'b0;
    logic                      fwd_mode = 1'b0;
    logic                      clr_cnt = 1'b0;
    logic                      id_valid = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr = '0;
    logic [NUM_SRC-1:0]        id_src_used = '0;
    logic [REG_AW-1:0]         id_dest = '0;
    logic                      id_reg_write = 1'b0;
    logic                      id_is_load = 1'b0;
    logic                      stall;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          load_use_cnt;
    logic [CNT_W-1:0]          fwd_cnt;
    logic [CNT_W-1:0]          issue_cnt;

    int n_checks = 0;
    int n_errors = 0;

    string       tag_q [$];
    int          kind_q[$];
    logic [31:0] val_q [$];

    pipe_hazard_ctrl #(
        .REG_AW    (REG_AW),
        .NUM_SRC   (NUM_SRC),
        .PIPE_DEPTH(PIPE_DEPTH),
        .CNT_W     (CNT_W),
        .SELW      (SELW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .fwd_mode    (fwd_mode),
        .clr_cnt     (clr_cnt),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dest     (id_dest),
        .id_reg_write(id_reg_write),
        .id_is_load  (id_is_load),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt),
        .load_use_cnt(load_use_cnt),
        .fwd_cnt     (fwd_cnt),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard drain: everything queued this cycle is compared on the falling edge.
    always @(negedge clk) begin
        string       t;
        int          k;
        logic [31:0] v;
        logic [31:0] obs;
        while (kind_q.size() > 0) begin
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            v = val_q.pop_front();
            case (k)
                K_STALL: obs = 32'(stall);
                K_SEL0:  obs = 32'(fwd_sel[SELW-1:0]);
                K_SEL1:  obs = 32'(fwd_sel[2*SELW-1:SELW]);
                K_SCNT:  obs = 32'(stall_cnt);
                K_LCNT:  obs = 32'(load_use_cnt);
                K_FCNT:  obs = 32'(fwd_cnt);
                default: obs = 32'(issue_cnt);
            endcase
            check(t, obs, v);
        end
    end

    task automatic expect_val(input string tag, input int kind, input int val);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        val_q.push_back(32'(val));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] dest, input logic rw, input logic ld);
        id_valid     = 1'b1;
        id_src_addr  = {s1, s0};
        id_src_used  = used;
        id_dest      = dest;
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_src_used  = '0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
    endtask

    task automatic drain_clear(input string tag);
        repeat (3) begin
            step();
            idle();
        end
        step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        expect_val({tag, "_clr_scnt"}, K_SCNT, 0);
        expect_val({tag, "_clr_icnt"}, K_ICNT, 0);
    endtask

    initial begin
        // Reset state
        step();
        instr(5'd3, 5'd4, 2'b11, 5'd3, 1'b1, 1'b1);
        expect_val("rst_stall", K_STALL, 0);
        expect_val("rst_sel0",  K_SEL0, 0);
        expect_val("rst_scnt",  K_SCNT, 0);
        expect_val("rst_lcnt",  K_LCNT, 0);
        expect_val("rst_fcnt",  K_FCNT, 0);
        expect_val("rst_icnt",  K_ICNT, 0);
        step();
        idle();

        // Stall-only RAW: two stall cycles, issue on the third
        step();
        reset = 1'b0;
        fwd_mode = 1'b0;
        instr(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
        expect_val("a_first_issue", K_STALL, 0);
        step();
        instr(5'd3, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
        expect_val("a_raw_stall1", K_STALL, 1);
        step();
        expect_val("a_raw_stall2", K_STALL, 1);
        step();
        expect_val("a_raw_issue", K_STALL, 0);
        expect_val("a_raw_sel0",  K_SEL0, 0);
        step();
        idle();
        expect_val("a_scnt", K_SCNT, 2);
        expect_val("a_icnt", K_ICNT, 2);
        drain_clear("a");

        // Load-use with forwarding
        step();
        fwd_mode = 1'b1;
        instr(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
        expect_val("b_lw_issue", K_STALL, 0);
        step();
        instr(5'd7, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0);
        expect_val("b_lu_stall", K_STALL, 1);
        step();
        expect_val("b_lu_release", K_STALL, 0);
        expect_val("b_sel1", K_SEL1, 2);
        expect_val("b_sel0", K_SEL0, 0);
        step();
        idle();
        expect_val("b_lcnt", K_LCNT, 1);
        expect_val("b_fcnt", K_FCNT, 1);
        expect_val("b_scnt", K_SCNT, 1);
        expect_val("b_icnt", K_ICNT, 2);
        drain_clear("b");

        // Youngest producer wins, r0 ignored, mode switch takes effect immediately
        step();
        instr(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
        step();
        instr(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
        step();
        instr(5'd4, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1);
        expect_val("c_young_stall", K_STALL, 0);
        expect_val("c_young_sel0",  K_SEL0, 1);
        expect_val("c_r0_sel1",     K_SEL1, 0);
        step();
        instr(5'd0, 5'd4, 2'b11, 5'd10, 1'b1, 1'b0);
        expect_val("c_r0w_stall", K_STALL, 0);
        expect_val("c_r0w_sel0",  K_SEL0, 0);
        expect_val("c_mid_sel1",  K_SEL1, 2);
        step();
        fwd_mode = 1'b0;
        instr(5'd10, 5'd0, 2'b01, 5'd11, 1'b0, 1'b0);
        expect_val("c_mode0_stall", K_STALL, 1);
        step();
        fwd_mode = 1'b1;
        expect_val("c_mode1_stall", K_STALL, 0);
        expect_val("c_mode1_sel0",  K_SEL0, 2);
        step();
        idle();
        expect_val("c_fcnt", K_FCNT, 3);
        expect_val("c_icnt", K_ICNT, 5);
        expect_val("c_lcnt", K_LCNT, 0);
        expect_val("c_scnt", K_SCNT, 1);
        drain_clear("c");

        // Hold freezes scoreboard and counters
        step();
        fwd_mode = 1'b0;
        instr(5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
        expect_val("d_issue", K_STALL, 0);
        step();
        instr(5'd11, 5'd0, 2'b01, 5'd12, 1'b0, 1'b0);
        hold = 1'b1;
        expect_val("d_hold_stall", K_STALL, 1);
        repeat (4) begin
            step();
            expect_val("d_hold_stall", K_STALL, 1);
        end
        step();
        hold = 1'b0;
        expect_val("d_post_stall", K_STALL, 1);
        expect_val("d_post_scnt",  K_SCNT, 0);
        expect_val("d_post_icnt",  K_ICNT, 1);
        step();
        expect_val("d_stall2", K_STALL, 1);
        expect_val("d_scnt1",  K_SCNT, 1);
        step();
        expect_val("d_release", K_STALL, 0);
        step();
        idle();
        expect_val("d_scnt", K_SCNT, 2);
        expect_val("d_icnt", K_ICNT, 2);
        drain_clear("d");

        // Flush suppresses stall and pushes a bubble
        step();
        instr(5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0);
        step();
        instr(5'd12, 5'd0, 2'b01, 5'd13, 1'b0, 1'b0);
        flush = 1'b1;
        expect_val("f_flush_stall", K_STALL, 0);
        step();
        flush = 1'b0;
        expect_val("f_after_stall", K_STALL, 1);
        expect_val("f_icnt", K_ICNT, 1);
        expect_val("f_scnt", K_SCNT, 0);
        step();
        expect_val("f_release", K_STALL, 0);
        step();
        idle();
        drain_clear("f");

        // Saturation: 20 stall cycles and 20 issues on a 4-bit counter
        for (int i = 0; i < 10; i++) begin
            step();
            instr(5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0);
            expect_val("e_sat_scnt", K_SCNT, (2 * i > 15) ? 15 : 2 * i);
            expect_val("e_sat_icnt", K_ICNT, (2 * i > 15) ? 15 : 2 * i);
            step();
            instr(5'd13, 5'd0, 2'b01, 5'd14, 1'b0, 1'b0);
            expect_val("e_sat_stall", K_STALL, 1);
            step();
            step();
        end
        step();
        idle();
        expect_val("e_sat_scnt_final", K_SCNT, 15);
        expect_val("e_sat_icnt_final", K_ICNT, 15);

        // Clear coincident with a stall, then clear during hold
        step();
        instr(5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0);
        step();
        instr(5'd13, 5'd0, 2'b01, 5'd14, 1'b0, 1'b0);
        clr_cnt = 1'b1;
        expect_val("g_clr_stall", K_STALL, 1);
        step();
        clr_cnt = 1'b0;
        expect_val("g_clr_scnt", K_SCNT, 0);
        expect_val("g_clr_icnt", K_ICNT, 0);
        step();
        expect_val("g_after_scnt", K_SCNT, 1);
        step();
        idle();
        hold = 1'b1;
        clr_cnt = 1'b1;
        expect_val("g_hold_scnt", K_SCNT, 1);
        expect_val("g_hold_icnt", K_ICNT, 1);
        step();
        hold = 1'b0;
        clr_cnt = 1'b0;
        expect_val("g_holdclr_scnt", K_SCNT, 0);
        expect_val("g_holdclr_icnt", K_ICNT, 0);

        // Reset in the middle of a stall discards in-flight state
        step();
        instr(5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 1'b0);
        step();
        instr(5'd14, 5'd0, 2'b01, 5'd15, 1'b0, 1'b0);
        expect_val("r_pre_stall", K_STALL, 1);
        step();
        reset = 1'b1;
        expect_val("r_in_stall", K_STALL, 0);
        expect_val("r_in_icnt",  K_ICNT, 0);
        step();
        reset = 1'b0;
        expect_val("r_first_stall", K_STALL, 0);
        expect_val("r_first_sel0",  K_SEL0, 0);
        step();
        idle();
        expect_val("r_icnt", K_ICNT, 1);
        expect_val("r_scnt", K_SCNT, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- PIPE_DEPTH, 3, stages between issue and register write (EX, MEM, WB).
- CNT_W, 32, event counter width.
- SELW, $clog2(PIPE_DEPTH+1), forward-select width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- hold, in, 1, global pipeline freeze.
- flush, in, 1, kill the instruction in ID.
- fwd_mode, in, 1, 1 = forwarding enabled, 0 = stall-only.
- clr_cnt, in, 1, synchronous counter clear.
- id_valid, in, 1, ID holds an instruction.
- id_src_addr, in, NUM_SRC*REG_AW, packed source register addresses.
- id_src_used, in, NUM_SRC, per-source read enable.
- id_dest, in, REG_AW, destination register.
- id_reg_write, in, 1, instruction writes the register file.
- id_is_load, in, 1, instruction is a memory load.
- stall, out, 1, freeze IF/ID and do not issue.
- fwd_sel, out, NUM_SRC*SELW, per-source forward select.
- stall_cnt, out, CNT_W, stall cycles.
- load_use_cnt, out, CNT_W, load-use stall cycles.
- fwd_cnt, out, CNT_W, forwarded operand count.
- issue_cnt, out, CNT_W, issued instructions.

Function
REQ-003 An internal scoreboard of PIPE_DEPTH entries {v, wr, ld, dest} SHALL model in-flight instructions; entry 0 = youngest (EX), entry PIPE_DEPTH-1 = WB.
REQ-004 Each clk with hold=0: entry k+1 <= entry k; entry 0 <= {1, id_reg_write, id_is_load, id_dest} if issue, else a bubble (v=0).
REQ-005 issue = id_valid & !stall & !flush.
REQ-006 hold=1 SHALL freeze all scoreboard entries and all counters.
REQ-007 Source s matches entry k iff id_src_used[s], entry k v&wr, dest==src addr, and src addr != 0.
REQ-008 fwd_mode=0: hazard iff any used source matches any entry k < PIPE_DEPTH-1; the WB stage writes first half-cycle, so a WB match is no hazard.
REQ-009 fwd_mode=1: hazard iff any used source matches entry 0 with ld=1 (load-use).
REQ-010 stall SHALL be combinational = id_valid & hazard & !flush; flush SHALL suppress stall.
REQ-011 fwd_sel[s] SHALL be combinational:
- 0 when fwd_mode=0 or no match.
- Otherwise k+1 for the smallest matching k (youngest producer wins).
REQ-012 fwd_sel SHALL be valid only when stall=0; its value during stall is don't-care.
REQ-013 fwd_mode SHALL take effect on the same cycle it changes.
REQ-014 Counters SHALL update only when hold=0, saturate at 2^CNT_W-1, and never wrap.
- stall_cnt +1 per stall cycle.
- load_use_cnt +1 per stall cycle caused under REQ-009.
- issue_cnt +1 per issue.
- fwd_cnt + number of sources with nonzero fwd_sel on an issue cycle.
REQ-015 clr_cnt=1 SHALL zero all counters on the next edge and take priority over any simultaneous increment, including during hold.
REQ-016 A stall pushes a bubble, so a stall-only RAW resolves after at most PIPE_DEPTH-1 stall cycles with no external feedback.

Reset
REQ-017 While reset=1, asynchronously:
- All scoreboard entries SHALL be v=0.
- All counters SHALL be 0.
- Hence stall=0 and fwd_sel=0.
REQ-018 Reset asserted mid-stall SHALL discard all in-flight state.
REQ-019 After reset deasserts, the first id_valid instruction SHALL issue without stall.

Verification
REQ-020 RAW, stall-only: fwd_mode=0, issue add r3, then next cycle a source reads r3 -> stall=1 for exactly 2 cycles, issue on 3rd; stall_cnt=2.
REQ-021 Load-use with forwarding: fwd_mode=1, lw r5 then a source reads r5 -> stall=1 for exactly 1 cycle, then fwd_sel=2; load_use_cnt=1, fwd_cnt=1.
REQ-022 Youngest wins and r0 is ignored:
- r4 written by entries 0 and 1, fwd_mode=1, non-load -> fwd_sel=1.
- A source reading r0 against an r0 writer -> fwd_sel=0, no stall.
REQ-023 Hold and flush:
- hazard with hold=1 for 5 cycles -> scoreboard and counters frozen.
- flush=1 with a hazard -> stall=0, bubble pushed, issue_cnt unchanged.
REQ-024 Saturation and clear:
- CNT_W=4, 20 stall cycles -> stall_cnt=15.
- clr_cnt coincident with a stall -> stall_cnt=0.
- Reset mid-stall -> stall=0 on the following cycle.
